// File: rtl/bram_arbiter_pkg.sv
// Shared definitions for the BRAM arbiter.
//   AW, DW       : default memory address / data widths
//   MAX_BURST    : default maximum accesses per grant
//   REQ_*        : requester indices (bit positions in req/gnt/rvalid)
//   state_t      : arbiter FSM states
//   onehot4()    : 2-bit index to 4-bit one-hot vector
package bram_arbiter_pkg;

   localparam int AW        = 13;
   localparam int DW        = 8;
   localparam int MAX_BURST = 256;

   localparam logic [1:0] REQ_CHECK = 2'd0;
   localparam logic [1:0] REQ_LDIN  = 2'd1;
   localparam logic [1:0] REQ_LDW   = 2'd2;
   localparam logic [1:0] REQ_OUT   = 2'd3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   function automatic logic [3:0] onehot4(input logic [1:0] idx);
      onehot4 = 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/bram_arbiter_rr_pick.sv
// Combinational winner selection for the BRAM arbiter.
//   req    : request vector (bit 0 = check, absolute priority)
//   rr     : round-robin start point among requesters 1..3
//   winner : index of the selected requester (0 when nothing is requested)
//   any    : at least one request present
module rr_pick
   import bram_arbiter_pkg::*;
(
   input  logic [3:0] req,
   input  logic [1:0] rr,
   output logic [1:0] winner,
   output logic       any
);

   logic [1:0] cand;
   logic       found;

   assign any = |req;

   always_comb begin
      winner = REQ_CHECK;
      found  = 1'b0;
      // rr never legitimately holds 0; treat it as 1 so the scan stays in 1..3
      cand   = (rr == 2'd0) ? 2'd1 : rr;
      if (req[REQ_CHECK]) begin
         found = 1'b1;
      end
      for (int k = 0; k < 3; k++) begin
         if (!found && req[cand]) begin
            winner = cand;
            found  = 1'b1;
         end
         cand = (cand == 2'd3) ? 2'd1 : cand + 2'd1;
      end
   end

endmodule

// File: rtl/bram_arbiter.sv
// Four-requester arbiter in front of a single-port BRAM.
//   clk, rst          : clock, asynchronous active-high reset
//   req/last/we       : per-requester request, end-of-burst flag, write enable
//   addr/wdata        : per-requester address and write data, packed by index
//   gnt               : registered one-hot grant
//   rvalid/rdata      : one-hot read strobe one cycle after a read, shared data
//   mem_we/addr/din   : BRAM port driven from the owner while an access fires
//   mem_dout          : BRAM read data (one cycle latency)
//   busy              : FSM is in BUSY
module bram_arbiter #(
   parameter int AW        = bram_arbiter_pkg::AW,
   parameter int DW        = bram_arbiter_pkg::DW,
   parameter int MAX_BURST = bram_arbiter_pkg::MAX_BURST
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [3:0]      req,
   input  logic [3:0]      last,
   input  logic [3:0]      we,
   input  logic [4*AW-1:0] addr,
   input  logic [4*DW-1:0] wdata,
   output logic [3:0]      gnt,
   output logic [3:0]      rvalid,
   output logic [DW-1:0]   rdata,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_din,
   input  logic [DW-1:0]   mem_dout,
   output logic            busy
);
   import bram_arbiter_pkg::*;

   localparam int CW = $clog2(MAX_BURST) + 1;
   localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);

   state_t        state_reg, state_next;
   logic [1:0]    owner_reg, owner_next;
   logic [1:0]    rr_reg, rr_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [3:0]    gnt_reg, gnt_next;
   logic [3:0]    rvalid_reg, rvalid_next;
   logic [AW-1:0] addr_hold_reg;
   logic [DW-1:0] din_hold_reg;

   logic [AW-1:0] addr_arr  [4];
   logic [DW-1:0] wdata_arr [4];

   logic [1:0]    pick_winner;
   logic          pick_any;
   logic          fire;
   logic          release_now;

   for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
      assign addr_arr[gi]  = addr[gi*AW +: AW];
      assign wdata_arr[gi] = wdata[gi*DW +: DW];
   end

   rr_pick u_rr_pick (
      .req    (req),
      .rr     (rr_reg),
      .winner (pick_winner),
      .any    (pick_any)
   );

   // gnt is only ever set for owner_reg, so this is gnt[i] & req[i] for any i
   assign fire = gnt_reg[owner_reg] & req[owner_reg];

   // A burst ends on its last access, when the owner withdraws, or when the
   // access about to fire is the MAX_BURST-th one of this grant.
   assign release_now = !req[owner_reg] ||
                        (fire && (last[owner_reg] || cnt_reg == BURST_LAST));

   always_comb begin
      state_next  = state_reg;
      owner_next  = owner_reg;
      rr_next     = rr_reg;
      cnt_next    = cnt_reg;
      gnt_next    = gnt_reg;
      rvalid_next = (fire && !we[owner_reg]) ? onehot4(owner_reg) : 4'b0000;
      case (state_reg)
         ST_IDLE: begin
            gnt_next = 4'b0000;
            if (pick_any) begin
               owner_next = pick_winner;
               cnt_next   = '0;
               gnt_next   = onehot4(pick_winner);
               state_next = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (fire) begin
               cnt_next = cnt_reg + CW'(1);
            end
            if (release_now) begin
               gnt_next   = 4'b0000;
               state_next = ST_IDLE;
               // check does not take part in the rotation
               if (owner_reg != REQ_CHECK) begin
                  rr_next = (owner_reg == REQ_OUT) ? REQ_LDIN : owner_reg + 2'd1;
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
            gnt_next   = 4'b0000;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         owner_reg     <= REQ_CHECK;
         rr_reg        <= REQ_LDIN;
         cnt_reg       <= '0;
         gnt_reg       <= 4'b0000;
         rvalid_reg    <= 4'b0000;
         addr_hold_reg <= '0;
         din_hold_reg  <= '0;
      end else begin
         state_reg  <= state_next;
         owner_reg  <= owner_next;
         rr_reg     <= rr_next;
         cnt_reg    <= cnt_next;
         gnt_reg    <= gnt_next;
         rvalid_reg <= rvalid_next;
         if (fire) begin
            addr_hold_reg <= addr_arr[owner_reg];
            din_hold_reg  <= wdata_arr[owner_reg];
         end
      end
   end

   // Idle cycles replay the last driven address/data so the BRAM port is quiet
   assign mem_we   = fire & we[owner_reg];
   assign mem_addr = fire ? addr_arr[owner_reg]  : addr_hold_reg;
   assign mem_din  = fire ? wdata_arr[owner_reg] : din_hold_reg;

   assign gnt    = gnt_reg;
   assign rvalid = rvalid_reg;
   assign rdata  = (|rvalid_reg) ? mem_dout : '0;
   assign busy   = (state_reg == ST_BUSY);

endmodule

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 Parameter AW, 13, memory address width (matches the 13-bit memaddr space).
REQ-002 Parameter DW, 8, memory data width.
REQ-003 Parameter MAX_BURST, 256, maximum accesses per grant before forced release.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req  input  4  access request; bit0 = bram check, bit1 = input loader, bit2 = weight loader, bit3 = output writer.
REQ-007 last  input  4  per-requester flag marking the final access of its burst.
REQ-008 we  input  4  per-requester write enable (1 = write, 0 = read).
REQ-009 addr  input  4*AW  per-requester address; requester i occupies bits [i*AW +: AW].
REQ-010 wdata  input  4*DW  per-requester write data; requester i occupies bits [i*DW +: DW].
REQ-011 gnt  output  4  one-hot grant (at most one bit set), registered.
REQ-012 rvalid  output  4  one-hot read-data-valid strobe, routed to the requester that issued the read.
REQ-013 rdata  output  DW  read data, shared by all requesters and qualified by rvalid.
REQ-014 mem_we  output  1  BRAM write enable.
REQ-015 mem_addr  output  AW  BRAM address.
REQ-016 mem_din  output  DW  BRAM write data.
REQ-017 mem_dout  input  DW  BRAM read data, valid one cycle after the read address is presented.
REQ-018 busy  output  1  high while in BUSY.

Function
REQ-019 Two-state FSM: IDLE and BUSY, with an owner register (2 bits), a round-robin pointer rr (2 bits), and a burst counter (width clog2(MAX_BURST)+1).
REQ-020 IDLE, req != 0: select winner, load owner, go to BUSY, and set gnt[owner] on the following edge; the arbitration costs exactly one cycle.
REQ-021 Winner rule: req[0] always wins; otherwise the first set bit among 1..3, scanning cyclically from rr.
REQ-022 IDLE, req == 0: stay in IDLE with gnt = 0.
REQ-023 Access fires in any cycle where gnt[i] & req[i]; mem_addr, mem_we and mem_din are combinational muxes of requester i's addr, we and wdata.
REQ-024 When no access fires, mem_we = 0 and mem_addr/mem_din hold their last driven values.
REQ-025 Reads: rvalid[i] pulses exactly one cycle after the firing read, and rdata = mem_dout in that cycle; a write produces no rvalid.
REQ-026 Bursts are locked: no other requester, including check, can preempt an active grant.
REQ-027 Release to IDLE (gnt cleared on the next edge) on any of: a firing access with last[owner] = 1; req[owner] = 0 in BUSY; the burst counter reaching MAX_BURST on a firing access.
REQ-028 On every release from owner 1..3, rr becomes owner+1, wrapping from 3 to 1; a release from owner 0 leaves rr unchanged.
REQ-029 The burst counter clears on entry to BUSY and increments on each firing access.
REQ-030 A read pending at release still delivers its rvalid in the following cycle, even while the FSM is back in IDLE.
REQ-031 Changes to req bits other than the owner's have no effect while in BUSY.

Reset
REQ-032 rst high asynchronously forces: IDLE, owner = 0, rr = 1, burst counter = 0, gnt = 0, rvalid = 0, busy = 0, mem_we = 0, mem_addr = 0, mem_din = 0, rdata = 0.
REQ-033 Reset mid-burst discards any pending rvalid; after rst falls, the first arbitration takes place in the first IDLE cycle.

Structure
REQ-034 A shared package holds AW, DW and the requester index constants REQ_CHECK = 0, REQ_LDIN = 1, REQ_LDW = 2 and REQ_OUT = 3.
REQ-035 One sub-module, rr_pick, contains the combinational priority plus round-robin selector (inputs req, rr; outputs winner and any).

Verification
REQ-036 req = 4'b0110 from IDLE with rr = 1 -> gnt = 4'b0010 one cycle later; after release, the next arbitration grants 4'b0100.
REQ-037 Owner 1 reads addr 1 then 2 (last on addr 2), with memory holding 8'h30 and 8'h40 -> rvalid[1] high two consecutive cycles, rdata = 30 then 40; gnt drops the cycle after the addr-2 access.
REQ-038 Owner 3 mid-burst, req[0] rises with addr 233 -> gnt stays 4'b1000 until last[3]; then, after one IDLE cycle, gnt = 4'b0001.
REQ-039 Owner 2 writes continuously with last = 0 and MAX_BURST = 4 -> exactly 4 writes with mem_we = 1, then gnt = 0 and re-arbitration.
REQ-040 rst asserted while a read is outstanding -> gnt, rvalid and busy go to 0 immediately, and no rvalid appears afterward.
REQ-041 All four req bits held high continuously -> check wins every arbitration; with req[0] low, grants rotate through 1, 2, 3, 1.
